// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// Holds the FSM state enum, ALU-op class, opcode/funct/ALU codes and mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTEXEC,
    S_ALUWB,
    S_BEQ,
    S_BLT,
    S_ADDIEXEC,
    S_ADDIWB,
    S_JUMP
  } state_t;

  typedef enum logic [1:0] {
    AOP_NONE,
    AOP_ADD,
    AOP_SUB,
    AOP_FUNCT
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLT   = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: op class + funct -> alucontrol, flags unknown R-type functs.
// Ports: aluop, funct in; alucontrol (zero-extended), funct_illegal out.
module mc_aludec
  import mc_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  aluop_t               aluop,
  input  logic [5:0]           funct,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 funct_illegal
);

  logic [3:0] code;

  always_comb begin
    code          = 4'b0000;
    funct_illegal = 1'b0;
    unique case (aluop)
      AOP_ADD: code = ALU_ADD;
      AOP_SUB: code = ALU_SUB;
      AOP_FUNCT: begin
        unique case (funct)
          F_ADD:   code = ALU_ADD;
          F_SUB:   code = ALU_SUB;
          F_AND:   code = ALU_AND;
          F_OR:    code = ALU_OR;
          F_SLT:   code = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: code = 4'b0000;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller: FSM, Moore output decode, retire counter.
// In: clk, reset, op, funct, zero, lessthan, mem_ready. Out: datapath
// enables/selects, alucontrol, illegal pulse, instr_count.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W     = 32,
  parameter bit MEM_WAIT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 lessthan,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 irwrite,
  output logic                 pcen,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic                 memwrite,
  output logic                 memtoreg,
  output logic                 regdst,
  output logic                 regwrite,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic [CNT_W-1:0]     instr_count
);

  state_t state, state_n;
  aluop_t aluop;
  logic   rdy;
  logic   funct_illegal;
  logic   pcwrite, branch, blt;
  logic   irwrite_m, memwrite_m, regwrite_m;
  logic   illegal_m, retire;

  assign rdy = MEM_WAIT ? mem_ready : 1'b1;

  mc_aludec #(
    .ALUCTRL_W(ALUCTRL_W)
  ) u_aludec (
    .aluop        (aluop),
    .funct        (funct),
    .alucontrol   (alucontrol),
    .funct_illegal(funct_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset)       instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

  // ALU op class depends on state only, kept apart from the
  // next-state block that consumes funct_illegal.
  always_comb begin
    aluop = AOP_NONE;
    unique case (state)
      S_FETCH, S_DECODE, S_MEMADR,
      S_ADDIEXEC:   aluop = AOP_ADD;
      S_BEQ, S_BLT: aluop = AOP_SUB;
      S_RTEXEC:     aluop = AOP_FUNCT;
      default:      aluop = AOP_NONE;
    endcase
  end

  always_comb begin
    state_n    = state;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    pcsrc      = PC_ALU;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    irwrite_m  = 1'b0;
    memwrite_m = 1'b0;
    regwrite_m = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    blt        = 1'b0;
    illegal_m  = 1'b0;
    retire     = 1'b0;
    unique case (state)
      S_FETCH: begin
        alusrcb = SRCB_4;
        pcsrc   = PC_ALU;
        if (rdy) begin
          irwrite_m = 1'b1;
          pcwrite   = 1'b1;
          state_n   = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        unique case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_RTEXEC;
          OP_BEQ:       state_n = S_BEQ;
          OP_BLT:       state_n = S_BLT;
          OP_ADDI:      state_n = S_ADDIEXEC;
          OP_J:         state_n = S_JUMP;
          default: begin
            illegal_m = 1'b1;
            state_n   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (rdy) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite_m = 1'b1;
        memtoreg   = 1'b1;
        retire     = 1'b1;
        state_n    = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_m = 1'b1;
        if (rdy) begin
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_RTEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_B;
        if (funct_illegal) begin
          illegal_m = 1'b1;
          state_n   = S_FETCH;
        end else begin
          state_n = S_ALUWB;
        end
      end
      S_ALUWB: begin
        regwrite_m = 1'b1;
        regdst     = 1'b1;
        retire     = 1'b1;
        state_n    = S_FETCH;
      end
      S_BEQ: begin
        alusrca = 1'b1;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_BLT: begin
        alusrca = 1'b1;
        pcsrc   = PC_ALUOUT;
        blt     = 1'b1;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_n = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_m = 1'b1;
        retire     = 1'b1;
        state_n    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  // State-changing strobes are suppressed while reset is held.
  assign irwrite  = irwrite_m & ~reset;
  assign memwrite = memwrite_m & ~reset;
  assign regwrite = regwrite_m & ~reset;
  assign illegal  = illegal_m & ~reset;
  assign pcen     = (pcwrite | (branch & zero) | (blt & lessthan))
                  & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller against an
// instruction-level timeline model; also covers MEM_WAIT=0 and CNT_W=4.
module tb_multicycle_controller;

  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BLT  = 6'b000110;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] J    = 6'b000010;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic [5:0] alu;
    logic       illegal;
  } ctl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, zero, lessthan, mem_ready;
  logic [5:0]  op, funct;
  logic        iord, irwrite, pcen, alusrca;
  logic [1:0]  alusrcb, pcsrc;
  logic        memwrite, memtoreg, regdst, regwrite, illegal;
  logic [5:0]  alucontrol;
  logic [31:0] instr_count;

  logic        reset2, zero2, lessthan2, mem_ready2;
  logic [5:0]  op2, funct2;

  logic        nw_iord, nw_irwrite, nw_pcen, nw_alusrca;
  logic [1:0]  nw_alusrcb, nw_pcsrc;
  logic        nw_memwrite, nw_memtoreg, nw_regdst;
  logic        nw_regwrite, nw_illegal;
  logic [3:0]  nw_alu;
  logic [31:0] nw_count;

  logic        c4_iord, c4_irwrite, c4_pcen, c4_alusrca;
  logic [1:0]  c4_alusrcb, c4_pcsrc;
  logic        c4_memwrite, c4_memtoreg, c4_regdst;
  logic        c4_regwrite, c4_illegal;
  logic [3:0]  c4_alu;
  logic [3:0]  c4_count;

  multicycle_controller #(.ALUCTRL_W(6)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .zero(zero), .lessthan(lessthan), .mem_ready(mem_ready),
    .iord(iord), .irwrite(irwrite), .pcen(pcen),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .memwrite(memwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alucontrol(alucontrol),
    .illegal(illegal), .instr_count(instr_count)
  );

  multicycle_controller #(.MEM_WAIT(1'b0)) dut_nw (
    .clk(clk), .reset(reset2), .op(op2), .funct(funct2),
    .zero(zero2), .lessthan(lessthan2), .mem_ready(mem_ready2),
    .iord(nw_iord), .irwrite(nw_irwrite), .pcen(nw_pcen),
    .alusrca(nw_alusrca), .alusrcb(nw_alusrcb), .pcsrc(nw_pcsrc),
    .memwrite(nw_memwrite), .memtoreg(nw_memtoreg),
    .regdst(nw_regdst), .regwrite(nw_regwrite),
    .alucontrol(nw_alu), .illegal(nw_illegal),
    .instr_count(nw_count)
  );

  multicycle_controller #(.CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset2), .op(op2), .funct(funct2),
    .zero(zero2), .lessthan(lessthan2), .mem_ready(mem_ready2),
    .iord(c4_iord), .irwrite(c4_irwrite), .pcen(c4_pcen),
    .alusrca(c4_alusrca), .alusrcb(c4_alusrcb), .pcsrc(c4_pcsrc),
    .memwrite(c4_memwrite), .memtoreg(c4_memtoreg),
    .regdst(c4_regdst), .regwrite(c4_regwrite),
    .alucontrol(c4_alu), .illegal(c4_illegal),
    .instr_count(c4_count)
  );

  int checks = 0;
  int failures = 0;
  int unsigned exp_count = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit op_ok(input logic [5:0] o);
    return o inside {RT, LW, SW, BEQ, BLT, ADDI, J};
  endfunction

  function automatic bit fok(input logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100,
                     6'b100101, 6'b101010};
  endfunction

  function automatic logic [5:0] fcode(input logic [5:0] f);
    case (f)
      6'b100000: return 6'd2;
      6'b100010: return 6'd6;
      6'b100100: return 6'd0;
      6'b100101: return 6'd1;
      6'b101010: return 6'd7;
      default:   return 6'd0;
    endcase
  endfunction

  // Cycles per instruction when memory never stalls.
  function automatic int ncyc(input logic [5:0] o, input logic [5:0] f);
    if (!op_ok(o)) return 2;
    case (o)
      LW:       return 5;
      SW, ADDI: return 4;
      RT:       return fok(f) ? 4 : 3;
      default:  return 3;
    endcase
  endfunction

  // Cycles that wait on memory: instruction fetch and data access.
  function automatic bit wait_k(input logic [5:0] o, input int k);
    return (k == 0) || (k == 3 && (o == LW || o == SW));
  endfunction

  function automatic bit retires(input logic [5:0] o,
                                 input logic [5:0] f);
    return op_ok(o) && (o != RT || fok(f));
  endfunction

  function automatic ctl_t exp_ctl(input logic [5:0] o, input logic [5:0] f,
                                   input int k, input logic r,
                                   input logic z, input logic lt);
    ctl_t e;
    e = '0;
    if (k == 0) begin
      e.alusrcb = 2'b01;
      e.alu     = 6'd2;
      e.irwrite = r;
      e.pcen    = r;
    end else if (k == 1) begin
      e.alusrcb = 2'b11;
      e.alu     = 6'd2;
      e.illegal = !op_ok(o);
    end else begin
      case (o)
        LW, SW: begin
          if (k == 2) begin
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
            e.alu     = 6'd2;
          end else if (k == 3) begin
            e.iord     = 1'b1;
            e.memwrite = (o == SW);
          end else begin
            e.regwrite = 1'b1;
            e.memtoreg = 1'b1;
          end
        end
        RT: begin
          if (k == 2) begin
            e.alusrca = 1'b1;
            e.alu     = fcode(f);
            e.illegal = !fok(f);
          end else begin
            e.regwrite = 1'b1;
            e.regdst   = 1'b1;
          end
        end
        BEQ, BLT: begin
          e.alusrca = 1'b1;
          e.alu     = 6'd6;
          e.pcsrc   = 2'b01;
          e.pcen    = (o == BEQ) ? z : lt;
        end
        ADDI: begin
          if (k == 2) begin
            e.alusrca = 1'b1;
            e.alusrcb = 2'b10;
            e.alu     = 6'd2;
          end else begin
            e.regwrite = 1'b1;
          end
        end
        default: begin
          e.pcsrc = 2'b10;
          e.pcen  = 1'b1;
        end
      endcase
    end
    return e;
  endfunction

  // fst/mst: not-ready cycles in fetch / data access.
  // abort_k: cycle index at which reset is asserted (-1 = none).
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input logic lt,
                           input int fst, input int mst,
                           input int abort_k);
    int   k;
    int   n;
    logic r;
    ctl_t e, a, m;
    k = 0;
    n = ncyc(o, f);
    while (k < n) begin
      @(negedge clk);
      r = 1'b1;
      if (wait_k(o, k)) begin
        if (k == 0 && fst > 0) begin
          r = 1'b0;
          fst--;
        end else if (k != 0 && mst > 0) begin
          r = 1'b0;
          mst--;
        end
      end
      op = o;
      funct = f;
      zero = z;
      lessthan = lt;
      mem_ready = r;
      if (k == abort_k) begin
        reset = 1'b1;
        #1;
        chk("abort_strobes",
            64'({irwrite, pcen, memwrite, regwrite, illegal}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_count = 0;
        chk("abort_count", 64'(instr_count), 64'(0));
        return;
      end
      #1;
      e = exp_ctl(o, f, k, r, z, lt);
      a = {iord, irwrite, pcen, alusrca, alusrcb, pcsrc, memwrite,
           memtoreg, regdst, regwrite, alucontrol, illegal};
      m = '1;
      if (o == RT && k == 2 && !fok(f)) m.alu = '0;
      chk($sformatf("op%b_f%b_k%0d_r%0d", o, f, k, r),
          64'(a & m), 64'(e & m));
      if (!wait_k(o, k) || r) k++;
    end
    if (retires(o, f)) exp_count++;
    @(posedge clk);
    #1;
    chk($sformatf("count_after_op%b", o),
        64'(instr_count), 64'(exp_count));
  endtask

  initial begin
    reset = 1'b1;
    op = '0;
    funct = '0;
    zero = 1'b0;
    lessthan = 1'b0;
    mem_ready = 1'b1;
    reset2 = 1'b1;
    op2 = '0;
    funct2 = '0;
    zero2 = 1'b0;
    lessthan2 = 1'b0;
    mem_ready2 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_strobes",
        64'({irwrite, pcen, memwrite, regwrite, illegal}), 64'(0));
    chk("reset_count", 64'(instr_count), 64'(0));
    chk("reset_fetch_srcb", 64'(alusrcb), 64'(2'b01));
    reset = 1'b0;

    run_instr(LW, 6'h00, 1'b0, 1'b0, 0, 0, -1);
    run_instr(SW, 6'h00, 1'b0, 1'b0, 0, 3, -1);
    run_instr(BEQ, 6'h00, 1'b1, 1'b0, 0, 0, -1);
    run_instr(BEQ, 6'h00, 1'b0, 1'b1, 0, 0, -1);
    run_instr(BLT, 6'h00, 1'b0, 1'b1, 0, 0, -1);
    run_instr(BLT, 6'h00, 1'b1, 1'b0, 0, 0, -1);
    run_instr(RT, 6'b101010, 1'b0, 1'b0, 0, 0, -1);
    run_instr(RT, 6'b111111, 1'b0, 1'b0, 0, 0, -1);
    run_instr(6'b111111, 6'h00, 1'b0, 1'b0, 0, 0, -1);
    run_instr(ADDI, 6'h00, 1'b0, 1'b0, 2, 0, -1);
    run_instr(J, 6'h00, 1'b0, 1'b0, 0, 0, -1);
    run_instr(LW, 6'h00, 1'b0, 1'b0, 0, 2, 3);
    run_instr(ADDI, 6'h00, 1'b0, 1'b0, 0, 0, -1);
    run_instr(LW, 6'h00, 1'b0, 1'b0, 0, 0, 4);
    run_instr(LW, 6'h00, 1'b0, 1'b0, 1, 2, -1);

    for (int i = 0; i < 60; i++) begin
      logic [5:0] o;
      logic [5:0] f;
      case ($urandom_range(0, 7))
        0:       o = RT;
        1:       o = LW;
        2:       o = SW;
        3:       o = BEQ;
        4:       o = BLT;
        5:       o = ADDI;
        6:       o = J;
        default: o = 6'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       f = 6'b100000;
        1:       f = 6'b100010;
        2:       f = 6'b100100;
        3:       f = 6'b100101;
        4:       f = 6'b101010;
        default: f = 6'($urandom);
      endcase
      run_instr(o, f, 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                -1);
    end

    // MEM_WAIT=0: sw completes in 4 cycles with mem_ready held low.
    @(negedge clk);
    reset2 = 1'b0;
    op2 = SW;
    mem_ready2 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c == 0) begin
        chk("nw_fetch_irwrite", 64'(nw_irwrite), 64'(1));
        chk("waitcfg_fetch_stall", 64'(c4_irwrite), 64'(0));
      end
      chk($sformatf("nw_memwrite_c%0d", c),
          64'(nw_memwrite), 64'(c == 3));
      @(negedge clk);
    end
    chk("nw_count", 64'(nw_count), 64'(1));

    // CNT_W=4: sixteen addi retirements wrap the counter.
    @(posedge clk);
    #1;
    reset2 = 1'b1;
    mem_ready2 = 1'b1;
    op2 = ADDI;
    @(posedge clk);
    #1;
    reset2 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("c4_count_%0d", i), 64'(c4_count), 64'(i % 16));
    end
    chk("nw_count_16", 64'(nw_count), 64'(16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
